// File: rtl/toom8_pkg.sv
// rtl/toom8_pkg.sv - shared constants and helpers for the Toom-8 pointwise multiply stage
package toom8_pkg;

  localparam int OPW_DEF   = 155;
  localparam int PRODW_DEF = 2 * OPW_DEF;
  localparam int NUM_PTS   = 15;
  localparam int INF_IDX   = 14;
  localparam int IDXW      = 4;

  // Index that should follow idx in a frame; infinity (and the illegal 15) wrap to 0.
  function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] idx);
    return (idx >= IDXW'(INF_IDX)) ? '0 : idx + IDXW'(1);
  endfunction

endpackage

// File: rtl/toom8_mul_pipe.sv
// rtl/toom8_mul_pipe.sv - signed multiplier with input register and MUL_LAT result stages
module toom8_mul_pipe
  import toom8_pkg::*;
#(
  parameter int OPW     = OPW_DEF,
  parameter int MUL_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [IDXW-1:0]   in_idx,
  input  logic [OPW-1:0]    in_a,
  input  logic [OPW-1:0]    in_b,
  output logic              out_valid,
  output logic [IDXW-1:0]   out_idx,
  output logic [2*OPW-1:0]  out_data
);

  localparam int PW = 2 * OPW;

  logic                in_vld_q;
  logic [IDXW-1:0]     in_idx_q;
  logic [OPW-1:0]      a_q;
  logic [OPW-1:0]      b_q;
  logic [MUL_LAT-1:0]  vld_q;
  logic [IDXW-1:0]     idx_q [MUL_LAT];
  logic [PW-1:0]       dat_q [MUL_LAT];
  logic signed [PW-1:0] prod;

  // Operands are sign-extended to full product width so the product is exact.
  assign prod = $signed({{OPW{a_q[OPW-1]}}, a_q}) * $signed({{OPW{b_q[OPW-1]}}, b_q});

  // Valid bits are the only reset state of the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_vld_q <= 1'b0;
      vld_q    <= '0;
    end else begin
      in_vld_q <= in_valid;
      vld_q[0] <= in_vld_q;
      for (int i = 1; i < MUL_LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // Data and index ride alongside the valid bits without reset.
  always_ff @(posedge clk) begin
    a_q      <= in_a;
    b_q      <= in_b;
    in_idx_q <= in_idx;
    idx_q[0] <= in_idx_q;
    dat_q[0] <= prod;
    for (int i = 1; i < MUL_LAT; i++) begin
      idx_q[i] <= idx_q[i-1];
      dat_q[i] <= dat_q[i-1];
    end
  end

  assign out_valid = vld_q[MUL_LAT-1];
  assign out_idx   = idx_q[MUL_LAT-1];
  assign out_data  = dat_q[MUL_LAT-1];

endmodule

// File: rtl/toom8_pointwise_mult.sv
// rtl/toom8_pointwise_mult.sv - pointwise product stage with credit flow control, FIFO and sequence check
module toom8_pointwise_mult
  import toom8_pkg::*;
#(
  parameter int MUL_LAT    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int OPW        = OPW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pt_valid,
  output logic              pt_ready,
  input  logic [3:0]        pt_idx,
  input  logic [OPW-1:0]    pt_a,
  input  logic [OPW-1:0]    pt_b,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [3:0]        w_idx,
  output logic [2*OPW-1:0]  w_data,
  output logic              frame_done,
  output logic              seq_err
);

  localparam int PW = 2 * OPW;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic            accept, consume;
  logic            p_valid;
  logic [3:0]      p_idx;
  logic [PW-1:0]   p_data;

  logic            init_q;
  logic [CW-1:0]   credit_q, credit_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [3:0]      exp_q, exp_d;
  logic            seq_err_q, seq_err_d;
  logic            frame_done_q, frame_done_d;
  logic [PW-1:0]   mem_q  [FIFO_DEPTH];
  logic [3:0]      midx_q [FIFO_DEPTH];

  // Credit covers everything in the pipe plus the FIFO, so a FIFO slot always waits for each accept.
  assign pt_ready   = init_q && (credit_q < CW'(FIFO_DEPTH));
  assign accept     = pt_valid && pt_ready;
  assign w_valid    = (count_q != '0);
  assign consume    = w_valid && w_ready;
  assign w_data     = mem_q[rd_ptr_q];
  assign w_idx      = midx_q[rd_ptr_q];
  assign frame_done = frame_done_q;
  assign seq_err    = seq_err_q;

  toom8_mul_pipe #(.OPW(OPW), .MUL_LAT(MUL_LAT)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (accept),
    .in_idx    (pt_idx),
    .in_a      (pt_a),
    .in_b      (pt_b),
    .out_valid (p_valid),
    .out_idx   (p_idx),
    .out_data  (p_data)
  );

  // Next-state for credit, FIFO pointers/occupancy, sequence checker and frame pulse.
  always_comb begin
    credit_d     = credit_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    exp_d        = exp_q;
    seq_err_d    = seq_err_q;
    frame_done_d = consume && (w_idx == 4'(INF_IDX));

    case ({accept, consume})
      2'b10:   credit_d = credit_q + CW'(1);
      2'b01:   credit_d = credit_q - CW'(1);
      default: credit_d = credit_q;
    endcase

    if (p_valid) wr_ptr_d = (wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    if (consume) rd_ptr_d = (rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);

    case ({p_valid, consume})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (accept) begin
      if (pt_idx != exp_q) seq_err_d = 1'b1;
      exp_d = next_idx(pt_idx);
    end
  end

  // Control state register; init_q holds pt_ready low until the first edge out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q       <= 1'b0;
      credit_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      exp_q        <= '0;
      seq_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      init_q       <= 1'b1;
      credit_q     <= credit_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      exp_q        <= exp_d;
      seq_err_q    <= seq_err_d;
      frame_done_q <= frame_done_d;
    end
  end

  // FIFO storage written as each product leaves the multiplier pipe.
  always_ff @(posedge clk) begin
    if (p_valid) begin
      mem_q[wr_ptr_q]  <= p_data;
      midx_q[wr_ptr_q] <= p_idx;
    end
  end

endmodule

// File: tb/tb_toom8_pointwise_mult.sv
// tb/tb_toom8_pointwise_mult.sv - randomized bench with queue reference model for toom8_pointwise_mult
module tb_toom8_pointwise_mult;
  localparam int OPW   = 155;
  localparam int PW    = 2 * OPW;
  localparam int LAT   = 4;
  localparam int DEPTH = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            pt_valid = 1'b0;
  logic            pt_ready;
  logic [3:0]      pt_idx = '0;
  logic [OPW-1:0]  pt_a = '0;
  logic [OPW-1:0]  pt_b = '0;
  logic            w_valid;
  logic            w_ready = 1'b0;
  logic [3:0]      w_idx;
  logic [PW-1:0]   w_data;
  logic            frame_done;
  logic            seq_err;

  always #5 clk = ~clk;

  toom8_pointwise_mult #(.MUL_LAT(LAT), .FIFO_DEPTH(DEPTH), .OPW(OPW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pt_valid   (pt_valid),
    .pt_ready   (pt_ready),
    .pt_idx     (pt_idx),
    .pt_a       (pt_a),
    .pt_b       (pt_b),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_idx      (w_idx),
    .w_data     (w_data),
    .frame_done (frame_done),
    .seq_err    (seq_err)
  );

  typedef struct {
    logic [3:0]    idx;
    logic [PW-1:0] data;
    int            arr;
  } exp_t;

  exp_t          q[$];
  int            cyc = 0;
  int            credit_m = 0;
  int            acc_cnt = 0;
  int            cons_cnt = 0;
  int            fd_cnt = 0;
  bit            started = 1'b0;
  bit            seq_m = 1'b0;
  bit            fd_m = 1'b0;
  int            exp_m = 0;
  bit            m_ready;
  bit            rnd_rdy = 1'b0;
  logic [PW-1:0] obs [16];
  int            checks = 0;
  int            failures = 0;

  assign m_ready = started && (credit_m < DEPTH);

  function automatic logic [PW-1:0] mul_ref(input logic signed [OPW-1:0] a, input logic signed [OPW-1:0] b);
    logic signed [PW-1:0] ea, eb;
    ea = a;
    eb = b;
    return ea * eb;
  endfunction

  task automatic chk(input string name, input logic [PW-1:0] got, input logic [PW-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Reference model: frame order queue, arrival time, credit and sequence rules.
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      credit_m <= 0;
      started  <= 1'b0;
      seq_m    <= 1'b0;
      exp_m    <= 0;
      fd_m     <= 1'b0;
    end else begin
      automatic bit acc  = pt_valid && m_ready;
      automatic bit cons = (q.size() > 0) && (q[0].arr <= cyc) && w_ready;
      automatic exp_t e;
      fd_m <= cons && (q[0].idx == 4'd14);
      if (cons) begin
        obs[w_idx] <= w_data;
        void'(q.pop_front());
        cons_cnt <= cons_cnt + 1;
      end
      if (acc) begin
        e.idx  = pt_idx;
        e.data = mul_ref(pt_a, pt_b);
        e.arr  = cyc + 1 + LAT + 1;
        q.push_back(e);
        acc_cnt <= acc_cnt + 1;
        if (int'(pt_idx) != exp_m) seq_m <= 1'b1;
        exp_m <= (pt_idx >= 4'd14) ? 0 : int'(pt_idx) + 1;
      end
      credit_m <= credit_m + int'(acc) - int'(cons);
      started  <= 1'b1;
    end
    cyc <= cyc + 1;
  end

  // Compare process: every cycle, DUT outputs against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_pt_ready", pt_ready, 0);
      chk("rst_w_valid", w_valid, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_seq_err", seq_err, 0);
    end else begin
      automatic bit ev = (q.size() > 0) && (q[0].arr <= cyc);
      chk("pt_ready", pt_ready, m_ready);
      chk("w_valid", w_valid, ev);
      if (ev) begin
        chk("w_idx", w_idx, q[0].idx);
        chk("w_data", w_data, q[0].data);
      end
      chk("frame_done", frame_done, fd_m);
      chk("seq_err", seq_err, seq_m);
      if (frame_done) fd_cnt++;
    end
  end

  task automatic tick();
    @(negedge clk);
    if (rnd_rdy) w_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input int idx, input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    int n;
    pt_valid = 1'b1;
    pt_idx   = 4'(idx);
    pt_a     = a;
    pt_b     = b;
    n = 0;
    while (!pt_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL send_timeout idx=%0d", idx);
    end
    tick();
    pt_valid = 1'b0;
  endtask

  task automatic wait_wv(output int n);
    n = 0;
    while (!w_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_w_valid", w_valid, 0);
    chk("rst_async_pt_ready", pt_ready, 0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
    tick();
  endtask

  function automatic logic [OPW-1:0] rand_op();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    case ($urandom_range(0, 7))
      0:       return {1'b1, {(OPW-1){1'b0}}};
      1:       return {1'b0, {(OPW-1){1'b1}}};
      2:       return OPW'($urandom_range(0, 20));
      3:       return -OPW'($urandom_range(1, 20));
      default: return r[OPW-1:0];
    endcase
  endfunction

  initial begin
    int n;
    int base;
    logic [OPW-1:0] bneg, bpos;
    logic [PW-1:0]  one;
    int s_idx;

    one  = PW'(1);
    bneg = {1'b1, {(OPW-1){1'b0}}};
    bpos = ~bneg;

    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    chk("ready_after_reset", pt_ready, 1);

    // 3 * -5 with idle downstream ready: latency and value.
    w_ready = 1'b1;
    send(0, OPW'(3), -OPW'(5));
    wait_wv(n);
    chk("latency", n, 5);
    chk("prod_3x-5", w_data, -PW'(15));
    chk("idx_3x-5", w_idx, 0);
    tick();

    // Extreme operands.
    do_reset();
    w_ready = 1'b1;
    send(0, bneg, bneg);
    wait_wv(n);
    chk("prod_negmax_sq", w_data, one << 308);
    tick();
    send(1, bpos, bneg);
    wait_wv(n);
    chk("prod_posmax_negmax", w_data, -(one << 308) + (one << 154));
    repeat (5) tick();

    // Backpressure: exactly DEPTH accepted, then release.
    do_reset();
    w_ready = 1'b0;
    base = acc_cnt;
    for (int i = 0; i < 8; i++) send(i, rand_op(), rand_op());
    pt_valid = 1'b1;
    pt_idx   = 4'd8;
    repeat (10) tick();
    chk("bp_accepted", acc_cnt - base, 8);
    chk("bp_pt_ready", pt_ready, 0);
    base = fd_cnt;
    w_ready = 1'b1;
    for (int i = 8; i < 15; i++) send(i, rand_op(), rand_op());
    repeat (20) tick();
    chk("bp_frame_done_once", fd_cnt - base, 1);
    chk("bp_all_out", acc_cnt, cons_cnt);

    // Out-of-order index 0,1,3 then 4.
    do_reset();
    w_ready = 1'b1;
    base = cons_cnt;
    send(0, OPW'(1), OPW'(2));
    send(1, OPW'(3), OPW'(4));
    chk("seq_ok_before", seq_err, 0);
    send(3, OPW'(5), OPW'(6));
    chk("seq_err_set", seq_err, 1);
    send(4, OPW'(7), OPW'(8));
    repeat (12) tick();
    chk("seq_err_sticky", seq_err, 1);
    chk("seq_emitted", cons_cnt - base, 4);

    // Full frame with A=B=x^7 at points 1,-1,2,-2,..,7,-7,inf.
    do_reset();
    w_ready = 1'b1;
    for (int i = 0; i < 16; i++) obs[i] = '0;
    for (int i = 0; i < 15; i++) begin
      longint x, p;
      logic [OPW-1:0] v;
      x = (i % 2 == 0) ? longint'(i / 2 + 1) : -longint'(i / 2 + 1);
      p = 1;
      for (int k = 0; k < 7; k++) p = p * x;
      v = (i == 14) ? OPW'(1) : OPW'(p);
      send(i, v, v);
    end
    repeat (15) tick();
    chk("pow_idx0", obs[0], 1);
    chk("pow_idx1", obs[1], 1);
    chk("pow_idx14", obs[14], 1);
    chk("pow_idx2", obs[2], PW'(16384));
    chk("pow_idx13", obs[13], PW'(64'd678223072849));

    // Randomized traffic with random downstream stalls and occasional bad indices.
    do_reset();
    rnd_rdy = 1'b1;
    s_idx = 0;
    for (int t = 0; t < 500; t++) begin
      int id;
      id = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 15)) : s_idx;
      send(id, rand_op(), rand_op());
      s_idx = (id >= 14) ? 0 : id + 1;
      repeat ($urandom_range(0, 2)) tick();
    end
    rnd_rdy = 1'b0;
    w_ready = 1'b1;
    repeat (30) tick();
    chk("rand_drained", acc_cnt, cons_cnt);

    // Reset with 3 products in flight and 2 buffered.
    do_reset();
    w_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(i, rand_op(), rand_op());
    tick();
    tick();
    chk("pre_rst_w_valid", w_valid, 1);
    do_reset();
    w_ready = 1'b1;
    base = cons_cnt;
    repeat (20) tick();
    chk("no_stale_after_rst", cons_cnt - base, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
